int_sequencer: RTL and testbench

- Multi-cycle controller that takes the decode stage through interrupt entry and RTI return.
- On an accepted interrupt it freezes fetch and drains the pipeline. It then pushes PC-low, PC-high and CCR onto the stack and redirects the PC to the interrupt vector.
- On RTI it issues the three pops in reverse order and then re-enables fetch.
- Sits beside the decode-stage control unit and drives the stack/PC-select control lines during the sequences; the control unit owns them the rest of the time.

---
 rtl/int_sequencer.sv | 173 +++++++++++++++++
 tb/tb_int_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : int_sequencer
//  Purpose  : Decode-stage interrupt entry / RTI return sequencer. On an
//             accepted interrupt it freezes fetch, drains the pipeline, pushes
//             PC-low, PC-high and CCR, then redirects the PC to VEC_ADDR.
//             On RTI it pops CCR, PC-high, PC-low and resumes fetch.
//  Options  : `define INT_SEQ_MASK_EN adds an interrupt-enable bit that makes
//             the handler non-reentrant until its RTI completes.
//  Revision : 1.0 - initial release
// ============================================================================
module int_sequencer #(
    parameter int          DRAIN_CYC = 3,
    parameter logic [31:0] VEC_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        interrupt,
    input  logic        rti_req,
    input  logic        load_use,
    input  logic        mem_stall,
    input  logic [31:0] pc_in,
    input  logic [2:0]  ccr_in,
    output logic        busy,
    output logic        freeze_cu,
    output logic        fetch_pc_enable,
    output logic        stack_push,
    output logic [15:0] push_data,
    output logic        pop_pc1_sig,
    output logic        pop_pc2_sig,
    output logic        pop_ccr_sig,
    output logic        pc_load,
    output logic [31:0] pc_jmp,
    output logic        int_ack
);

    // Drain counter only has to hold DRAIN_CYC-1
    localparam int                 c_cnt_w      = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [c_cnt_w-1:0] c_drain_load = c_cnt_w'(DRAIN_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_DRAIN    = 4'd1,
        S_PUSH_PCL = 4'd2,
        S_PUSH_PCH = 4'd3,
        S_PUSH_CCR = 4'd4,
        S_VECTOR   = 4'd5,
        S_POP_CCR  = 4'd6,
        S_POP_PCH  = 4'd7,
        S_POP_PCL  = 4'd8,
        S_RESUME   = 4'd9
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_int_pending;
    logic [31:0]          r_saved_pc;
    logic [2:0]           r_saved_ccr;
    logic [c_cnt_w-1:0]   r_drain_cnt;
    logic                 w_int_enable;
    logic                 w_accept;

    // RTI wins over a simultaneous interrupt; a pulse seen during load_use
    // stays in r_int_pending so it is taken once the stall clears.
    assign w_accept = (r_state == S_IDLE) && !rti_req && !load_use &&
                      (r_int_pending || interrupt) && w_int_enable;

`ifdef INT_SEQ_MASK_EN
    logic r_int_enable;

    // Mask further interrupts from entry until the RTI sequence resumes fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_int_enable <= 1'b1;
        end else if (w_accept) begin
            r_int_enable <= 1'b0;
        end else if (r_state == S_RESUME) begin
            r_int_enable <= 1'b1;
        end
    end

    assign w_int_enable = r_int_enable;
`else
    assign w_int_enable = 1'b1;
`endif

    // Next-state selection; stack states hold while the stack memory is busy
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (rti_req) begin
                    w_state_nxt = S_POP_CCR;
                end else if (w_accept) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_state_nxt = S_PUSH_PCL;
                end
            end
            S_PUSH_PCL: if (!mem_stall) w_state_nxt = S_PUSH_PCH;
            S_PUSH_PCH: if (!mem_stall) w_state_nxt = S_PUSH_CCR;
            S_PUSH_CCR: if (!mem_stall) w_state_nxt = S_VECTOR;
            S_VECTOR:   w_state_nxt = S_IDLE;
            S_POP_CCR:  if (!mem_stall) w_state_nxt = S_POP_PCH;
            S_POP_PCH:  if (!mem_stall) w_state_nxt = S_POP_PCL;
            S_POP_PCL:  if (!mem_stall) w_state_nxt = S_RESUME;
            S_RESUME:   w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // State, context capture and Moore outputs decoded from the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_int_pending   <= 1'b0;
            r_saved_pc      <= 32'h0;
            r_saved_ccr     <= 3'b000;
            r_drain_cnt     <= '0;
            busy            <= 1'b0;
            freeze_cu       <= 1'b0;
            fetch_pc_enable <= 1'b1;
            stack_push      <= 1'b0;
            push_data       <= 16'h0;
            pop_pc1_sig     <= 1'b0;
            pop_pc2_sig     <= 1'b0;
            pop_ccr_sig     <= 1'b0;
            pc_load         <= 1'b0;
            pc_jmp          <= 32'h0;
            int_ack         <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // Any interrupt seen while not being accepted merges into one pending bit
            if (w_accept) begin
                r_int_pending <= 1'b0;
                r_saved_pc    <= pc_in;
                r_saved_ccr   <= ccr_in;
                r_drain_cnt   <= c_drain_load;
            end else begin
                r_int_pending <= r_int_pending | interrupt;
                if ((r_state == S_DRAIN) && (r_drain_cnt != '0)) begin
                    r_drain_cnt <= r_drain_cnt - c_cnt_one;
                end
            end

            busy            <= (w_state_nxt != S_IDLE);
            freeze_cu       <= (w_state_nxt != S_IDLE);
            fetch_pc_enable <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_VECTOR);
            stack_push      <= (w_state_nxt == S_PUSH_PCL) || (w_state_nxt == S_PUSH_PCH) ||
                               (w_state_nxt == S_PUSH_CCR);
            pop_ccr_sig     <= (w_state_nxt == S_POP_CCR);
            pop_pc2_sig     <= (w_state_nxt == S_POP_PCH);
            pop_pc1_sig     <= (w_state_nxt == S_POP_PCL);
            pc_load         <= (w_state_nxt == S_VECTOR);
            int_ack         <= (w_state_nxt == S_VECTOR);
            pc_jmp          <= (w_state_nxt == S_VECTOR) ? VEC_ADDR : 32'h0;

            case (w_state_nxt)
                S_PUSH_PCL: push_data <= r_saved_pc[15:0];
                S_PUSH_PCH: push_data <= r_saved_pc[31:16];
                S_PUSH_CCR: push_data <= {13'b0, r_saved_ccr};
                default:    push_data <= 16'h0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_int_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_int_sequencer
//  Purpose  : Self-checking bench for int_sequencer. A frame-queue model
//             predicts every output cycle; directed scenarios add literal
//             expectations on push/pop order, durations and ack counts.
//             Honours `define INT_SEQ_MASK_EN like the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_int_sequencer;

    localparam int          c_drain = 3;
    localparam logic [31:0] c_vec   = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        interrupt;
    logic        rti_req;
    logic        load_use;
    logic        mem_stall;
    logic [31:0] pc_in;
    logic [2:0]  ccr_in;
    logic        busy;
    logic        freeze_cu;
    logic        fetch_pc_enable;
    logic        stack_push;
    logic [15:0] push_data;
    logic        pop_pc1_sig;
    logic        pop_pc2_sig;
    logic        pop_ccr_sig;
    logic        pc_load;
    logic [31:0] pc_jmp;
    logic        int_ack;

    int_sequencer #(
        .DRAIN_CYC (c_drain),
        .VEC_ADDR  (c_vec)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .interrupt       (interrupt),
        .rti_req         (rti_req),
        .load_use        (load_use),
        .mem_stall       (mem_stall),
        .pc_in           (pc_in),
        .ccr_in          (ccr_in),
        .busy            (busy),
        .freeze_cu       (freeze_cu),
        .fetch_pc_enable (fetch_pc_enable),
        .stack_push      (stack_push),
        .push_data       (push_data),
        .pop_pc1_sig     (pop_pc1_sig),
        .pop_pc2_sig     (pop_pc2_sig),
        .pop_ccr_sig     (pop_ccr_sig),
        .pc_load         (pc_load),
        .pc_jmp          (pc_jmp),
        .int_ack         (int_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model: queue of expected output frames ----------------
    typedef struct packed {
        logic        busy;
        logic        freeze;
        logic        fetch_en;
        logic        push;
        logic [15:0] pdata;
        logic        pop1;
        logic        pop2;
        logic        popc;
        logic        pc_load;
        logic [31:0] jmp;
        logic        ack;
    } outs_t;

    typedef struct {
        outs_t o;
        bit    stallable;
        bit    resume;
    } frame_t;

    frame_t q[$];
    outs_t  m_exp;
    outs_t  dut_o;
    bit     m_valid = 1'b0;
    bit     m_pend  = 1'b0;
    bit     m_en    = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // observation logs, cleared per scenario
    int          busy_cnt, nofetch_cnt, ack_cnt, pch_hold;
    int          first_push_cyc, last_pop_cyc;
    logic [15:0] push_log[$];
    int          pop_log[$];

    assign dut_o = {busy, freeze_cu, fetch_pc_enable, stack_push, push_data,
                    pop_pc1_sig, pop_pc2_sig, pop_ccr_sig, pc_load, pc_jmp, int_ack};

    function automatic outs_t idle_o();
        outs_t o = '0;
        o.fetch_en = 1'b1;
        return o;
    endfunction

    function automatic outs_t seq_o();
        outs_t o = '0;
        o.busy   = 1'b1;
        o.freeze = 1'b1;
        return o;
    endfunction

    task automatic enq(input outs_t o, input bit stl, input bit res);
        frame_t f;
        f.o = o;
        f.stallable = stl;
        f.resume = res;
        q.push_back(f);
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge
    task automatic model_step();
        outs_t o;
        if (rst) begin
            q.delete();
            m_pend  = 1'b0;
            m_en    = 1'b1;
            m_valid = 1'b1;
        end else if (q.size() != 0) begin
            if (!(q[0].stallable && mem_stall)) begin
                if (q[0].resume) m_en = 1'b1;
                void'(q.pop_front());
            end
            if (interrupt) m_pend = 1'b1;
        end else if (rti_req) begin
            o = seq_o(); o.popc = 1'b1; enq(o, 1'b1, 1'b0);
            o = seq_o(); o.pop2 = 1'b1; enq(o, 1'b1, 1'b0);
            o = seq_o(); o.pop1 = 1'b1; enq(o, 1'b1, 1'b0);
            enq(seq_o(), 1'b0, 1'b1);
            if (interrupt) m_pend = 1'b1;
        end else if ((m_pend || interrupt) && !load_use && m_en) begin
            m_pend = 1'b0;
`ifdef INT_SEQ_MASK_EN
            m_en = 1'b0;
`endif
            for (int i = 0; i < c_drain; i++) enq(seq_o(), 1'b0, 1'b0);
            o = seq_o(); o.push = 1'b1; o.pdata = pc_in[15:0];      enq(o, 1'b1, 1'b0);
            o = seq_o(); o.push = 1'b1; o.pdata = pc_in[31:16];     enq(o, 1'b1, 1'b0);
            o = seq_o(); o.push = 1'b1; o.pdata = {13'b0, ccr_in};  enq(o, 1'b1, 1'b0);
            o = seq_o(); o.fetch_en = 1'b1; o.pc_load = 1'b1; o.jmp = c_vec; o.ack = 1'b1;
            enq(o, 1'b0, 1'b0);
        end else if (interrupt) begin
            m_pend = 1'b1;
        end
        m_exp = (q.size() != 0) ? q[0].o : idle_o();
    endtask

    task automatic observe();
        checks++;
        if (dut_o !== m_exp) begin
            errors++;
            $display("FAIL outputs cyc=%0d: got %h, expected %h", cyc, dut_o, m_exp);
        end
        if (busy) busy_cnt++;
        if (!fetch_pc_enable) nofetch_cnt++;
        if (int_ack) ack_cnt++;
        if (stack_push && push_data == 16'h0001) pch_hold++;
        if (stack_push && !mem_stall) begin
            if (push_log.size() == 0) first_push_cyc = cyc;
            push_log.push_back(push_data);
        end
        if (pop_ccr_sig && !mem_stall) begin pop_log.push_back(3); last_pop_cyc = cyc; end
        if (pop_pc2_sig && !mem_stall) begin pop_log.push_back(2); last_pop_cyc = cyc; end
        if (pop_pc1_sig && !mem_stall) begin pop_log.push_back(1); last_pop_cyc = cyc; end
        cyc++;
    endtask

    // Model steps on the rising edge, DUT compared on the falling edge
    always begin
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (m_valid) observe();
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        busy_cnt = 0; nofetch_cnt = 0; ack_cnt = 0; pch_hold = 0;
        first_push_cyc = -1; last_pop_cyc = -1;
        push_log.delete();
        pop_log.delete();
    endtask

    function automatic logic [31:0] push_at(input int i);
        if (i < push_log.size()) return {16'h0, push_log[i]};
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] pop_at(input int i);
        if (i < pop_log.size()) return pop_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got busy after %0d cycles, expected idle", n);
        end
    endtask

    task automatic do_rti();
        rti_req = 1'b1;
        step();
        rti_req = 1'b0;
        wait_idle();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst = 1'b1; interrupt = 1'b0; rti_req = 1'b0; load_use = 1'b0;
        mem_stall = 1'b0; pc_in = 32'h0; ccr_in = 3'b000;
        clear_logs();
        step();
        step();
        rst = 1'b0;

        // reset values
        chk("reset_busy", busy, 1'b0);
        chk("reset_fetch_en", fetch_pc_enable, 1'b1);
        chk("reset_strobes", {stack_push, pop_pc1_sig, pop_pc2_sig, pop_ccr_sig, pc_load, int_ack}, 6'b0);
        step();

        // basic entry
        clear_logs();
        pc_in = 32'h0001_2344; ccr_in = 3'b101; interrupt = 1'b1;
        step();
        interrupt = 1'b0;
        wait_idle();
        chk("entry_busy_cycles", busy_cnt, 7);
        chk("entry_nofetch_cycles", nofetch_cnt, 6);
        chk("entry_push0", push_at(0), 32'h2344);
        chk("entry_push1", push_at(1), 32'h0001);
        chk("entry_push2", push_at(2), 32'h0005);
        chk("entry_ack_count", ack_cnt, 1);
        step();

        // RTI
        clear_logs();
        do_rti();
        chk("rti_pop_count", pop_log.size(), 3);
        chk("rti_pop0_ccr", pop_at(0), 3);
        chk("rti_pop1_pch", pop_at(1), 2);
        chk("rti_pop2_pcl", pop_at(2), 1);
        chk("rti_busy_cycles", busy_cnt, 4);
        chk("rti_fetch_back", fetch_pc_enable, 1'b1);
        step();

        // RTI and interrupt in the same IDLE cycle
        clear_logs();
        pc_in = 32'hCAFE_0010; ccr_in = 3'b011;
        rti_req = 1'b1; interrupt = 1'b1;
        step();
        rti_req = 1'b0; interrupt = 1'b0;
        repeat (20) step();
        chk("coll_pop0_ccr", pop_at(0), 3);
        chk("coll_push_count", push_log.size(), 3);
        chk("coll_ack_count", ack_cnt, 1);
        chk("coll_gap", first_push_cyc - last_pop_cyc, 6);
        chk("coll_busy_cycles", busy_cnt, 11);
        do_rti();
        step();

        // interrupt pulse held off by load_use
        clear_logs();
        load_use = 1'b1; interrupt = 1'b1; pc_in = 32'hAAAA_5555;
        step();
        interrupt = 1'b0;
        step();
        pc_in = 32'h5555_AAAA;
        step();
        step();
        chk("lu_busy_while_stalled", busy_cnt, 0);
        load_use = 1'b0; pc_in = 32'h1234_BEEF; ccr_in = 3'b010;
        step();
        chk("lu_entry_started", busy, 1'b1);
        wait_idle();
        chk("lu_push0", push_at(0), 32'hBEEF);
        chk("lu_push1", push_at(1), 32'h1234);
        chk("lu_push2", push_at(2), 32'h0002);
        chk("lu_ack_count", ack_cnt, 1);
        do_rti();
        step();

        // mem_stall during PUSH_PCH
        clear_logs();
        pc_in = 32'h0001_2344; ccr_in = 3'b101; interrupt = 1'b1;
        step();
        interrupt = 1'b0;
        repeat (4) step();
        mem_stall = 1'b1;
        step();
        step();
        mem_stall = 1'b0;
        wait_idle();
        chk("stall_pch_hold", pch_hold, 3);
        chk("stall_push_count", push_log.size(), 3);
        chk("stall_push1", push_at(1), 32'h0001);
        chk("stall_busy_cycles", busy_cnt, 9);
        step();

        // reset in POP_PCH
        clear_logs();
        rti_req = 1'b1;
        step();
        rti_req = 1'b0;
        step();
        chk("rstmid_in_pop_pch", pop_pc2_sig, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_fetch_en", fetch_pc_enable, 1'b1);
        chk("rstmid_strobes", {stack_push, pop_pc1_sig, pop_pc2_sig, pop_ccr_sig, pc_load, int_ack}, 6'b0);
        step();

        // second interrupt arriving during the handler's entry
        clear_logs();
        pc_in = 32'h0000_0100; ccr_in = 3'b001; interrupt = 1'b1;
        step();
        interrupt = 1'b0;
        step();
        interrupt = 1'b1;
        step();
        interrupt = 1'b0;
        repeat (20) step();
`ifdef INT_SEQ_MASK_EN
        chk("reentry_acks_before_rti", ack_cnt, 1);
`else
        chk("reentry_acks_before_rti", ack_cnt, 2);
`endif
        rti_req = 1'b1;
        step();
        rti_req = 1'b0;
        repeat (25) step();
        chk("reentry_acks_total", ack_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
